param_lock_arbiter: RTL

//  N-requester arbiter with registered one-hot grant, runtime fixed/round-robin mode and
//  per-requester grant lock with bounded hold. Successor to the 4-way fixed-priority arbiter.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/arb_masked_pick.sv | 44 ++++
 rtl/param_lock_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the lock arbiter: mode/state encodings and one-hot decode.
package arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_LOCK  = 2'd2
    } arb_state_e;

    // Highest set bit wins; callers only pass one-hot or zero vectors.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_masked_pick.sv
// Combinational picker: first unmasked request at or above start_ptr, wrapping to index 0.
module arb_masked_pick
    import arb_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [ID_W-1:0]  start_ptr,
    output logic [N_REQ-1:0] pick,
    output logic [ID_W-1:0]  pick_id,
    output logic             pick_vld
);

    logic [N_REQ-1:0] cand;
    logic [ID_W:0]    sum;
    logic [ID_W-1:0]  idx;
    logic             found;

    assign cand = req & ~mask;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, start_ptr} + (ID_W + 1)'(off);
            if (sum >= (ID_W + 1)'(N_REQ)) begin
                sum = sum - (ID_W + 1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && cand[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign pick_id  = ID_W'(onehot_to_idx(32'(pick)));
    assign pick_vld = found;

endmodule

// File: rtl/param_lock_arbiter.sv
// N-way arbiter: registered one-hot grant, fixed/round-robin pick, bounded grant lock.
// Optional per-requester starvation monitor enabled by defining ARB_STARVE_MON_EN.
module param_lock_arbiter
    import arb_pkg::*;
#(
    parameter int  N_REQ        = 4,
    parameter int  MAX_LOCK     = 8,
    parameter int  STARVE_LIMIT = 16,
    localparam int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             arb_clk,
    input  logic             arb_rst_n,
    input  logic             arb_mode,
    input  logic [N_REQ-1:0] arb_req,
    input  logic [N_REQ-1:0] arb_lock,
    output logic [N_REQ-1:0] arb_gnt,
    output logic             arb_gnt_vld,
    output logic [ID_W-1:0]  arb_gnt_id,
    output logic             arb_locked,
    output logic [N_REQ-1:0] arb_starve,
    output arb_state_e       arb_state
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] lock_cnt;
    logic             forced_q;

    logic             hold_req;
    logic             lock_full;
    logic             force_exit;
    logic [N_REQ-1:0] pick_mask;
    logic [N_REQ-1:0] pick_oh;
    logic [ID_W-1:0]  pick_id;
    logic             pick_vld;
    logic [ID_W-1:0]  start_ptr;
    logic [N_REQ-1:0] sel_gnt;
    logic [ID_W-1:0]  sel_id;
    logic [ID_W-1:0]  sel_ptr;

    assign hold_req   = arb_req[arb_gnt_id] & arb_lock[arb_gnt_id];
    assign lock_full  = (lock_cnt == CNT_W'(MAX_LOCK));
    assign force_exit = (state == ARB_LOCK) && hold_req && lock_full;
    assign pick_mask  = force_exit ? arb_gnt : '0;
    assign start_ptr  = (arb_mode_e'(arb_mode) == ARB_RR) ? rr_ptr : '0;

    arb_masked_pick #(.N_REQ(N_REQ)) u_pick (
        .req       (arb_req),
        .mask      (pick_mask),
        .start_ptr (start_ptr),
        .pick      (pick_oh),
        .pick_id   (pick_id),
        .pick_vld  (pick_vld)
    );

    // A forced release with no competing request hands the grant straight back to the holder.
    assign sel_gnt = pick_vld ? pick_oh : arb_gnt;
    assign sel_id  = pick_vld ? pick_id : arb_gnt_id;
    assign sel_ptr = (sel_id == ID_W'(N_REQ - 1)) ? '0 : sel_id + ID_W'(1);

    always_ff @(posedge arb_clk) begin
        if (!arb_rst_n) begin
            state       <= ARB_IDLE;
            arb_gnt     <= '0;
            arb_gnt_vld <= 1'b0;
            arb_gnt_id  <= '0;
            arb_locked  <= 1'b0;
            rr_ptr      <= '0;
            lock_cnt    <= '0;
            forced_q    <= 1'b0;
        end else begin
            forced_q <= 1'b0;
            case (state)
                ARB_LOCK: begin
                    if (hold_req && !lock_full) begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end else begin
                        lock_cnt   <= '0;
                        arb_locked <= 1'b0;
                        if (arb_req == '0) begin
                            state       <= ARB_IDLE;
                            arb_gnt     <= '0;
                            arb_gnt_vld <= 1'b0;
                            arb_gnt_id  <= '0;
                        end else begin
                            state       <= ARB_GRANT;
                            arb_gnt     <= sel_gnt;
                            arb_gnt_vld <= 1'b1;
                            arb_gnt_id  <= sel_id;
                            rr_ptr      <= sel_ptr;
                            forced_q    <= !pick_vld;
                        end
                    end
                end
                default: begin
                    if (arb_req == '0) begin
                        state       <= ARB_IDLE;
                        arb_gnt     <= '0;
                        arb_gnt_vld <= 1'b0;
                        arb_gnt_id  <= '0;
                    end else if (state == ARB_GRANT && hold_req && !forced_q) begin
                        state      <= ARB_LOCK;
                        arb_locked <= 1'b1;
                        lock_cnt   <= CNT_W'(1);
                    end else begin
                        state       <= ARB_GRANT;
                        arb_gnt     <= sel_gnt;
                        arb_gnt_vld <= 1'b1;
                        arb_gnt_id  <= sel_id;
                        rr_ptr      <= sel_ptr;
                    end
                end
            endcase
        end
    end

    assign arb_state = state;

`ifdef ARB_STARVE_MON_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] wait_cnt [N_REQ];

    // Flag compares the registered count, so it rises one cycle after the count saturates.
    always_ff @(posedge arb_clk) begin
        if (!arb_rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
            arb_starve <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!arb_req[i] || arb_gnt[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != SW'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + SW'(1);
                end
                arb_starve[i] <= (wait_cnt[i] == SW'(STARVE_LIMIT));
            end
        end
    end
`else
    assign arb_starve = '0;
`endif

endmodule
